analog_tx: RTL and testbench

//  Downstream neighbour of the analog RX path. Waits for the analog macro to report compute finish.

---
 rtl/analog_macro_pkg.sv | 14 +
 rtl/analog_tx_stable_tracker.sv | 60 ++++++
 rtl/analog_tx.sv | 112 +++++++++++
 tb/tb_analog_tx.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/analog_macro_pkg.sv
// Shared types and default widths for the analog macro RX/TX neighbours.
package analog_macro_pkg;

  localparam int NUM_SPIN_DEF = 256;
  localparam int COUNTER_BITWIDTH_DEF = 8;
  localparam int STABLE_CNT_BITWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETTLE,
    TX_PUSH
  } analog_tx_state_e;

endpackage

// File: rtl/analog_tx_stable_tracker.sv
// Counts consecutive identical captured spin vectors and flags convergence
// once the count reaches a non-zero threshold.
module analog_tx_stable_tracker
  import analog_macro_pkg::*;
#(
  parameter int NUM_SPIN = NUM_SPIN_DEF,
  parameter int STABLE_CNT_BITWIDTH = STABLE_CNT_BITWIDTH_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           capture,
  input  logic                           clear,
  input  logic [STABLE_CNT_BITWIDTH-1:0] threshold,
  input  logic [NUM_SPIN-1:0]            spin,
  output logic                           converged
);

  localparam logic [STABLE_CNT_BITWIDTH-1:0] CNT_MAX = '1;

  logic [NUM_SPIN-1:0]            prev;
  logic                           has_prev;
  logic [STABLE_CNT_BITWIDTH-1:0] stable_cnt;
  logic [STABLE_CNT_BITWIDTH-1:0] stable_cnt_d;

  always_comb begin
    stable_cnt_d = stable_cnt;
    if (clear) begin
      stable_cnt_d = '0;
    end else if (capture) begin
      if (has_prev && spin == prev) begin
        if (stable_cnt != CNT_MAX)
          stable_cnt_d = stable_cnt + STABLE_CNT_BITWIDTH'(1);
      end else begin
        stable_cnt_d = '0;
      end
    end
  end

  // Converged follows the next count so it rises with the sample's valid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev       <= '0;
      has_prev   <= 1'b0;
      stable_cnt <= '0;
      converged  <= 1'b0;
    end else begin
      stable_cnt <= stable_cnt_d;
      converged  <= !clear && (threshold != '0)
                    && (stable_cnt_d >= threshold);
      if (clear) begin
        prev     <= '0;
        has_prev <= 1'b0;
      end else if (capture) begin
        prev     <= spin;
        has_prev <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/analog_tx.sv
// Samples analog macro spins after a settle delay and pushes them
// to the digital side over valid/ready, tracking sample stability.
module analog_tx
  import analog_macro_pkg::*;
#(
  parameter int NUM_SPIN = NUM_SPIN_DEF,
  parameter int COUNTER_BITWIDTH = COUNTER_BITWIDTH_DEF,
  parameter int STABLE_CNT_BITWIDTH = STABLE_CNT_BITWIDTH_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           en_i,
  input  logic                           tx_configure_enable_i,
  input  logic [COUNTER_BITWIDTH-1:0]    cycle_per_spin_sample_i,
  input  logic [STABLE_CNT_BITWIDTH-1:0] stable_threshold_i,
  input  logic                           analog_macro_cmpt_finish_i,
  input  logic [NUM_SPIN-1:0]            spin_i,
  output logic                           spin_push_valid_o,
  input  logic                           spin_push_ready_i,
  output logic [NUM_SPIN-1:0]            spin_push_o,
  output logic                           analog_tx_idle_o,
  output logic                           converged_o,
  output logic                           sample_overrun_o
);

  analog_tx_state_e state;

  logic [COUNTER_BITWIDTH-1:0]    cfg_settle;
  logic [STABLE_CNT_BITWIDTH-1:0] cfg_thr;
  logic [COUNTER_BITWIDTH-1:0]    cnt;
  logic finish_q;
  logic fin_rise;
  logic cfg_wr;
  logic handshake;
  logic capture;
  logic overrun_evt;

  assign cfg_wr    = en_i & tx_configure_enable_i;
  assign fin_rise  = analog_macro_cmpt_finish_i & ~finish_q;
  assign handshake = spin_push_valid_o & spin_push_ready_i;
  assign capture   = (state == TX_SETTLE) && (cnt == cfg_settle);

  assign spin_push_valid_o = (state == TX_PUSH);
  assign analog_tx_idle_o  = (state == TX_IDLE);

  assign overrun_evt = fin_rise &
    ((state == TX_SETTLE) | ((state == TX_PUSH) & ~handshake));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cfg_settle <= '0;
      cfg_thr    <= '0;
    end else if (cfg_wr) begin
      cfg_settle <= cycle_per_spin_sample_i;
      cfg_thr    <= stable_threshold_i;
    end
  end

  // Disable acts as a soft reset of everything except the config.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i) begin
      state            <= TX_IDLE;
      cnt              <= '0;
      finish_q         <= 1'b0;
      spin_push_o      <= '0;
      sample_overrun_o <= 1'b0;
    end else begin
      finish_q <= analog_macro_cmpt_finish_i;
      if (overrun_evt)
        sample_overrun_o <= 1'b1;
      else if (cfg_wr)
        sample_overrun_o <= 1'b0;
      unique case (state)
        TX_IDLE: begin
          if (fin_rise) begin
            state <= TX_SETTLE;
            cnt   <= '0;
          end
        end
        TX_SETTLE: begin
          if (capture) begin
            spin_push_o <= spin_i;
            state       <= TX_PUSH;
          end else begin
            cnt <= cnt + COUNTER_BITWIDTH'(1);
          end
        end
        TX_PUSH: begin
          if (handshake) begin
            state <= fin_rise ? TX_SETTLE : TX_IDLE;
            cnt   <= '0;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  analog_tx_stable_tracker #(
    .NUM_SPIN            (NUM_SPIN),
    .STABLE_CNT_BITWIDTH (STABLE_CNT_BITWIDTH)
  ) u_tracker (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .capture   (capture & en_i),
    .clear     (cfg_wr | ~en_i),
    .threshold (cfg_thr),
    .spin      (spin_i),
    .converged (converged_o)
  );

endmodule

// File: tb/tb_analog_tx.sv
// Self-checking bench for analog_tx using a transaction-level
// reference model of settle latency, data capture and convergence.
module tb_analog_tx;

  localparam int NS = 256;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          en_i;
  logic          cfg_en;
  logic [7:0]    cfg_settle;
  logic [7:0]    cfg_thr;
  logic          finish;
  logic [NS-1:0] spin_i;
  logic          valid;
  logic          ready;
  logic [NS-1:0] push;
  logic          idle;
  logic          conv;
  logic          overrun;

  int errors = 0;
  int checks = 0;

  logic [NS-1:0] m_prev;
  bit            m_has;
  int            m_cnt;
  int            m_thr;
  int            m_settle;

  always #5 clk = ~clk;

  analog_tx dut (
    .clk_i                      (clk),
    .rst_ni                     (rst_ni),
    .en_i                       (en_i),
    .tx_configure_enable_i      (cfg_en),
    .cycle_per_spin_sample_i    (cfg_settle),
    .stable_threshold_i         (cfg_thr),
    .analog_macro_cmpt_finish_i (finish),
    .spin_i                     (spin_i),
    .spin_push_valid_o          (valid),
    .spin_push_ready_i          (ready),
    .spin_push_o                (push),
    .analog_tx_idle_o           (idle),
    .converged_o                (conv),
    .sample_overrun_o           (overrun)
  );

  function automatic logic [NS-1:0] rand_vec();
    logic [NS-1:0] r;
    for (int i = 0; i < NS / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic bit exp_conv();
    return (m_thr != 0) && (m_cnt >= m_thr);
  endfunction

  task automatic model_capture(input logic [NS-1:0] v);
    if (m_has && v == m_prev) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    else m_cnt = 0;
    m_prev = v;
    m_has  = 1'b1;
  endtask

  task automatic model_clear();
    m_cnt = 0;
    m_has = 1'b0;
  endtask

  task automatic configure(input int settle, input int thr);
    cfg_en     = 1'b1;
    cfg_settle = 8'(settle);
    cfg_thr    = 8'(thr);
    @(negedge clk);
    cfg_en   = 1'b0;
    m_settle = settle;
    m_thr    = thr;
    model_clear();
    @(negedge clk);
  endtask

  // Raises finish for one cycle and counts cycles until valid appears.
  task automatic raise_wait(input logic [NS-1:0] v, output int lat);
    spin_i = v;
    finish = 1'b1;
    lat = -1;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (n == 1) finish = 1'b0;
      if (valid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic sample(input logic [NS-1:0] v, input int delay, input string tag);
    int lat;
    bit held;
    raise_wait(v, lat);
    model_capture(v);
    checks++;
    if (lat != m_settle + 2) begin
      errors++;
      $display("FAIL %s latency got %0d exp %0d", tag, lat, m_settle + 2);
    end
    checks++;
    if (push !== v) begin
      errors++;
      $display("FAIL %s data got %h exp %h", tag, push, v);
    end
    checks++;
    if (conv !== exp_conv()) begin
      errors++;
      $display("FAIL %s converged got %b exp %b (cnt %0d thr %0d)",
               tag, conv, exp_conv(), m_cnt, m_thr);
    end
    held = 1'b1;
    for (int i = 0; i < delay; i++) begin
      spin_i = rand_vec();
      @(negedge clk);
      if (valid !== 1'b1 || push !== v) held = 1'b0;
    end
    if (delay > 0) begin
      checks++;
      if (!held) begin
        errors++;
        $display("FAIL %s hold got %b exp 1", tag, held);
      end
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL %s after_hs valid=%b idle=%b exp 0/1", tag, valid, idle);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    en_i = 1'b1;
    cfg_en = 1'b0;
    cfg_settle = '0;
    cfg_thr = '0;
    finish = 1'b0;
    ready = 1'b0;
    spin_i = '0;
    m_settle = 0;
    m_thr = 0;
    model_clear();
    repeat (3) @(negedge clk);
    checks++;
    if ({valid, idle, conv, overrun} !== 4'b0100 || push !== '0) begin
      errors++;
      $display("FAIL reset v/i/c/o got %b%b%b%b push %h exp 0100 push 0",
               valid, idle, conv, overrun, push);
    end
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [NS-1:0] a5;
    a5 = {32{8'hA5}};
    configure(3, 2);
    sample(a5, 0, "basic");
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL basic overrun got %b exp 0", overrun);
    end
  endtask

  task automatic test_stable();
    logic [NS-1:0] v;
    v = rand_vec();
    configure(3, 2);
    for (int i = 0; i < 3; i++) sample(v, 0, "stable");
  endtask

  task automatic test_backpressure();
    logic [NS-1:0] v;
    int lat;
    bit held;
    bit quiet;
    v = rand_vec();
    configure(2, 2);
    raise_wait(v, lat);
    model_capture(v);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL bp latency got %0d exp 4", lat);
    end
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      finish = (i == 3);
      spin_i = rand_vec();
      @(negedge clk);
      if (valid !== 1'b1 || push !== v) held = 1'b0;
    end
    finish = 1'b0;
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL bp hold got %b exp 1", held);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp overrun got %b exp 1", overrun);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (valid !== 1'b0 || idle !== 1'b1) quiet = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL bp single_push got %b exp 1", quiet);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp overrun_sticky got %b exp 1", overrun);
    end
    configure(2, 2);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp overrun_clear got %b exp 0", overrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [NS-1:0] v;
    int lat;
    v = rand_vec();
    configure(0, 1);
    raise_wait(v, lat);
    model_capture(v);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL b2b latency got %0d exp 2", lat);
    end
    ready = 1'b1;
    finish = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    finish = 1'b0;
    checks++;
    if (valid !== 1'b0 || idle !== 1'b0) begin
      errors++;
      $display("FAIL b2b settle valid=%b idle=%b exp 0/0", valid, idle);
    end
    @(negedge clk);
    model_capture(v);
    checks++;
    if (valid !== 1'b1 || push !== v) begin
      errors++;
      $display("FAIL b2b second valid=%b push %h exp 1 %h", valid, push, v);
    end
    checks++;
    if (conv !== exp_conv()) begin
      errors++;
      $display("FAIL b2b converged got %b exp %b", conv, exp_conv());
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (overrun !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b overrun=%b valid=%b exp 0/0", overrun, valid);
    end
  endtask

  task automatic test_soft_clear();
    logic [NS-1:0] v;
    v = rand_vec();
    configure(5, 1);
    spin_i = v;
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    @(negedge clk);
    en_i = 1'b0;
    @(negedge clk);
    checks++;
    if (idle !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL en_clear idle=%b valid=%b exp 1/0", idle, valid);
    end
    en_i = 1'b1;
    model_clear();
    @(negedge clk);
    sample(v, 1, "reen1");
    sample(v, 0, "reen2");
  endtask

  task automatic test_reset_mid();
    logic [NS-1:0] v;
    v = rand_vec();
    configure(4, 1);
    sample(v, 0, "pre_rst1");
    sample(v, 0, "pre_rst2");
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    checks++;
    if ({valid, idle, conv, overrun} !== 4'b0100 || push !== '0) begin
      errors++;
      $display("FAIL rst_mid v/i/c/o got %b%b%b%b exp 0100",
               valid, idle, conv, overrun);
    end
    rst_ni = 1'b1;
    m_settle = 0;
    m_thr = 0;
    model_clear();
    @(negedge clk);
    sample(v, 0, "post_rst");
  endtask

  task automatic test_random();
    logic [NS-1:0] pool [3];
    logic [NS-1:0] v;
    for (int i = 0; i < 3; i++) pool[i] = rand_vec();
    configure(int'($urandom_range(0, 6)), int'($urandom_range(1, 3)));
    v = pool[0];
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) v = pool[$urandom_range(0, 2)];
      sample(v, int'($urandom_range(0, 3)), "random");
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL random overrun got %b exp 0", overrun);
    end
  endtask

  task automatic test_saturate();
    logic [NS-1:0] v;
    v = rand_vec();
    configure(0, 0);
    for (int i = 0; i < 300; i++) sample(v, 0, "thr0");
    configure(0, 255);
    for (int i = 0; i < 300; i++) sample(v, 0, "thr255");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stable();
    test_backpressure();
    test_back_to_back();
    test_soft_clear();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
